// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32I/M decode between IF/ID and ID/EX.
// Ports: clk/rst_n; in_valid/in_ready/in_instr/in_pc upstream;
//   flush; out_valid/out_ready downstream; out_pc, rd/rs1/rs2,
//   funct3, alu_op, mux1..3_select, regwrite_enable, mem_read,
//   mem_write, branch, jump, jal_select, imm_select, illegal,
//   div_busy (divider occupancy interlock).
module decode_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32,
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [4:0]      alu_op,
  output logic            mux1_select,
  output logic            mux2_select,
  output logic            mux3_select,
  output logic            regwrite_enable,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            jal_select,
  output logic [2:0]      imm_select,
  output logic            illegal,
  output logic            div_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b10000;
  localparam logic [4:0] ALU_SLL    = 5'b01101;
  localparam logic [4:0] ALU_SLT    = 5'b01111;
  localparam logic [4:0] ALU_SLTU   = 5'b10001;
  localparam logic [4:0] ALU_XOR    = 5'b00001;
  localparam logic [4:0] ALU_SRL    = 5'b10010;
  localparam logic [4:0] ALU_SRA    = 5'b01110;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_MUL    = 5'b00100;
  localparam logic [4:0] ALU_MULH   = 5'b00101;
  localparam logic [4:0] ALU_MULHSU = 5'b00111;
  localparam logic [4:0] ALU_MULHU  = 5'b00110;
  localparam logic [4:0] ALU_DIV    = 5'b01000;
  localparam logic [4:0] ALU_DIVU   = 5'b01001;
  localparam logic [4:0] ALU_REM    = 5'b01010;
  localparam logic [4:0] ALU_REMU   = 5'b01011;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  typedef struct packed {
    logic [4:0] alu;
    logic       m1;
    logic       m2;
    logic       m3;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       br;
    logic       jp;
    logic       js;
    logic [2:0] imm;
    logic       ill;
  } ctrl_t;

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;

  assign opc = in_instr[6:0];
  assign f7  = in_instr[31:25];
  assign f3  = in_instr[14:12];

  logic op_r, op_i, op_ld, op_st, op_br;
  logic op_jal, op_jalr, op_lui, op_aui;

  assign op_r    = (opc == 7'b0110011);
  assign op_i    = (opc == 7'b0010011);
  assign op_ld   = (opc == 7'b0000011);
  assign op_st   = (opc == 7'b0100011);
  assign op_br   = (opc == 7'b1100011);
  assign op_jal  = (opc == 7'b1101111);
  assign op_jalr = (opc == 7'b1100111);
  assign op_lui  = (opc == 7'b0110111);
  assign op_aui  = (opc == 7'b0010111);

  logic [CW-1:0] cnt;
  logic          is_div;
  logic          fire_in;
  logic          fire_out;

  assign div_busy = (cnt != '0);
  assign is_div   = ENABLE_M & op_r & (f7 == 7'b0000001) & f3[2];
  assign in_ready = (!out_valid | out_ready) & !(is_div & div_busy);
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  ctrl_t      c;
  logic [4:0] rs1_d;

  // LUI computes x0 + imm, so port A is pinned to x0.
  assign rs1_d = op_lui ? 5'd0 : in_instr[19:15];

  always_comb begin
    c     = '0;
    c.alu = ALU_ADD;
    unique case (1'b1)
      op_r: begin
        c.rw = 1'b1;
        unique case ({f7, f3})
          {7'h00, 3'd0}: c.alu = ALU_ADD;
          {7'h20, 3'd0}: c.alu = ALU_SUB;
          {7'h00, 3'd1}: c.alu = ALU_SLL;
          {7'h00, 3'd2}: c.alu = ALU_SLT;
          {7'h00, 3'd3}: c.alu = ALU_SLTU;
          {7'h00, 3'd4}: c.alu = ALU_XOR;
          {7'h00, 3'd5}: c.alu = ALU_SRL;
          {7'h20, 3'd5}: c.alu = ALU_SRA;
          {7'h00, 3'd6}: c.alu = ALU_OR;
          {7'h00, 3'd7}: c.alu = ALU_AND;
          {7'h01, 3'd0}: c.alu = ALU_MUL;
          {7'h01, 3'd1}: c.alu = ALU_MULH;
          {7'h01, 3'd2}: c.alu = ALU_MULHSU;
          {7'h01, 3'd3}: c.alu = ALU_MULHU;
          {7'h01, 3'd4}: c.alu = ALU_DIV;
          {7'h01, 3'd5}: c.alu = ALU_DIVU;
          {7'h01, 3'd6}: c.alu = ALU_REM;
          {7'h01, 3'd7}: c.alu = ALU_REMU;
          default:       c.ill = 1'b1;
        endcase
        if (f7 == 7'h01 && ENABLE_M == 1'b0)
          c.ill = 1'b1;
      end
      op_i: begin
        c.rw  = 1'b1;
        c.m2  = 1'b1;
        c.imm = IMM_I;
        unique case (f3)
          3'd0: c.alu = ALU_ADD;
          3'd2: c.alu = ALU_SLT;
          3'd3: c.alu = ALU_SLTU;
          3'd4: c.alu = ALU_XOR;
          3'd6: c.alu = ALU_OR;
          3'd7: c.alu = ALU_AND;
          3'd1: begin
            if (f7 == 7'h00) c.alu = ALU_SLL;
            else             c.ill = 1'b1;
          end
          default: begin
            if (f7 == 7'h00)      c.alu = ALU_SRL;
            else if (f7 == 7'h20) c.alu = ALU_SRA;
            else                  c.ill = 1'b1;
          end
        endcase
      end
      op_ld: begin
        c.m2  = 1'b1;
        c.m3  = 1'b1;
        c.mr  = 1'b1;
        c.rw  = 1'b1;
        c.imm = IMM_I;
        c.ill = (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
      end
      op_st: begin
        c.m2  = 1'b1;
        c.mw  = 1'b1;
        c.imm = IMM_S;
        c.ill = (f3 > 3'd2);
      end
      op_br: begin
        c.alu = ALU_SUB;
        c.br  = 1'b1;
        c.imm = IMM_B;
        c.ill = (f3 == 3'd2) | (f3 == 3'd3);
      end
      op_jal: begin
        c.jp  = 1'b1;
        c.js  = 1'b1;
        c.m1  = 1'b1;
        c.rw  = 1'b1;
        c.imm = IMM_J;
      end
      op_jalr: begin
        c.jp  = 1'b1;
        c.m2  = 1'b1;
        c.rw  = 1'b1;
        c.imm = IMM_I;
        c.ill = (f3 != 3'd0);
      end
      op_lui: begin
        c.m2  = 1'b1;
        c.rw  = 1'b1;
        c.imm = IMM_U;
      end
      op_aui: begin
        c.m1  = 1'b1;
        c.m2  = 1'b1;
        c.rw  = 1'b1;
        c.imm = IMM_U;
      end
      default: c.ill = 1'b1;
    endcase
    // An illegal bundle still flows downstream but must have no side effects.
    if (c.ill) begin
      c     = '0;
      c.alu = ALU_ADD;
      c.imm = IMM_NONE;
      c.ill = 1'b1;
    end
  end

  logic [XLEN-1:0] q_pc;
  logic [4:0]      q_rd;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [2:0]      q_f3;
  ctrl_t           q_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q_pc      <= '0;
      q_rd      <= '0;
      q_rs1     <= '0;
      q_rs2     <= '0;
      q_f3      <= '0;
      q_c       <= '0;
    end else begin
      if (flush)         out_valid <= 1'b0;
      else if (fire_in)  out_valid <= 1'b1;
      else if (fire_out) out_valid <= 1'b0;
      if (fire_in && !flush) begin
        q_pc  <= in_pc;
        q_rd  <= in_instr[11:7];
        q_rs1 <= rs1_d;
        q_rs2 <= in_instr[24:20];
        q_f3  <= f3;
        q_c   <= c;
      end
    end
  end

  // The divider keeps running across a flush, so only a fresh divide
  // reloads the count; otherwise it drains to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (fire_in && !flush && is_div)
      cnt <= CW'(DIV_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign out_pc          = q_pc;
  assign rd              = q_rd;
  assign rs1             = q_rs1;
  assign rs2             = q_rs2;
  assign funct3          = q_f3;
  assign alu_op          = q_c.alu;
  assign mux1_select     = q_c.m1;
  assign mux2_select     = q_c.m2;
  assign mux3_select     = q_c.m3;
  assign regwrite_enable = q_c.rw;
  assign mem_read        = q_c.mr;
  assign mem_write       = q_c.mw;
  assign branch          = q_c.br;
  assign jump            = q_c.jp;
  assign jal_select      = q_c.js;
  assign imm_select      = q_c.imm;
  assign illegal         = q_c.ill;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed plus random bench for decode_ctrl_stage.
// Reference model decodes from rule tables and tracks handshake state.
module tb_decode_ctrl_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [4:0]  alu;
    logic        m1, m2, m3, rw, mr, mw, br, jp, js;
    logic [2:0]  imm;
    logic        ill;
  } bun_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, div_busy;
  logic [31:0] out_pc;
  logic [4:0]  rd, rs1, rs2, alu_op;
  logic [2:0]  funct3, imm_select;
  logic        mux1_select, mux2_select, mux3_select;
  logic        regwrite_enable, mem_read, mem_write;
  logic        branch, jump, jal_select, illegal;

  logic        nm_in_ready, nm_out_valid, nm_div_busy;
  logic [31:0] nm_out_pc;
  logic [4:0]  nm_rd, nm_rs1, nm_rs2, nm_alu_op;
  logic [2:0]  nm_funct3, nm_imm_select;
  logic        nm_mux1, nm_mux2, nm_mux3;
  logic        nm_rw, nm_mr, nm_mw;
  logic        nm_br, nm_jp, nm_js, nm_illegal;

  decode_ctrl_stage #(.XLEN(32), .DIV_CYCLES(4), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .alu_op(alu_op),
    .mux1_select(mux1_select), .mux2_select(mux2_select),
    .mux3_select(mux3_select), .regwrite_enable(regwrite_enable),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .jal_select(jal_select), .imm_select(imm_select),
    .illegal(illegal), .div_busy(div_busy)
  );

  decode_ctrl_stage #(.XLEN(32), .DIV_CYCLES(4), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_pc(nm_out_pc),
    .rd(nm_rd), .rs1(nm_rs1), .rs2(nm_rs2), .funct3(nm_funct3),
    .alu_op(nm_alu_op),
    .mux1_select(nm_mux1), .mux2_select(nm_mux2),
    .mux3_select(nm_mux3), .regwrite_enable(nm_rw),
    .mem_read(nm_mr), .mem_write(nm_mw), .branch(nm_br),
    .jump(nm_jp), .jal_select(nm_js), .imm_select(nm_imm_select),
    .illegal(nm_illegal), .div_busy(nm_div_busy)
  );

  bun_t obs, nm_obs;
  assign obs = {out_pc, rd, rs1, rs2, funct3, alu_op,
                mux1_select, mux2_select, mux3_select,
                regwrite_enable, mem_read, mem_write,
                branch, jump, jal_select, imm_select, illegal};
  assign nm_obs = {nm_out_pc, nm_rd, nm_rs1, nm_rs2, nm_funct3,
                   nm_alu_op, nm_mux1, nm_mux2, nm_mux3,
                   nm_rw, nm_mr, nm_mw, nm_br, nm_jp, nm_js,
                   nm_imm_select, nm_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  logic [14:0] rtab [18];

  bit   m_valid;
  int   m_cnt;
  bun_t m_b;

  function automatic bun_t model(input logic [31:0] i,
                                 input logic [31:0] pc,
                                 input bit enm);
    bun_t b;
    bit   ok;
    logic [6:0] f7;
    logic [2:0] f3;
    b    = '0;
    ok   = 0;
    f7   = i[31:25];
    f3   = i[14:12];
    b.pc = pc;
    b.rd = i[11:7];
    b.rs1 = i[19:15];
    b.rs2 = i[24:20];
    b.f3 = f3;
    case (i[6:0])
      7'h33: begin
        foreach (rtab[k])
          if (rtab[k][14:5] == {f7, f3} && (f7 != 7'h01 || enm)) begin
            ok = 1; b.alu = rtab[k][4:0];
          end
        b.rw = ok;
      end
      7'h13: begin
        if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'h00;
        if (f7 != 7'h01)
          foreach (rtab[k])
            if (rtab[k][14:5] == {f7, f3} && {f7, f3} != {7'h20, 3'd0}) begin
              ok = 1; b.alu = rtab[k][4:0];
            end
        if (ok) begin b.m2 = 1; b.imm = 3'd1; b.rw = 1; end
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        ok = 1; b.m2 = 1; b.m3 = 1; b.mr = 1; b.rw = 1; b.imm = 3'd1;
      end
      7'h23: if (f3 <= 3'd2) begin
        ok = 1; b.m2 = 1; b.mw = 1; b.imm = 3'd2;
      end
      7'h63: if (!(f3 inside {3'd2, 3'd3})) begin
        ok = 1; b.alu = 5'h10; b.br = 1; b.imm = 3'd3;
      end
      7'h6F: begin
        ok = 1; b.jp = 1; b.js = 1; b.m1 = 1; b.rw = 1; b.imm = 3'd5;
      end
      7'h67: if (f3 == 3'd0) begin
        ok = 1; b.jp = 1; b.m2 = 1; b.rw = 1; b.imm = 3'd1;
      end
      7'h37: begin
        ok = 1; b.m2 = 1; b.rw = 1; b.imm = 3'd4; b.rs1 = 5'd0;
      end
      7'h17: begin
        ok = 1; b.m1 = 1; b.m2 = 1; b.rw = 1; b.imm = 3'd4;
      end
      default: ok = 0;
    endcase
    if (!ok) b.ill = 1;
    return b;
  endfunction

  function automatic bit div_of(input bun_t b);
    return !b.ill && b.alu >= 5'd8 && b.alu <= 5'd11;
  endfunction

  task automatic chkb(input string tag, input logic o, input logic x);
    checks++;
    assert (o === x) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, x);
    end
  endtask

  task automatic chkw(input string tag, input logic [67:0] o,
                      input logic [67:0] x);
    checks++;
    assert (o === x) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic check_state();
    chkb("out_valid", out_valid, m_valid);
    chkb("div_busy", div_busy, m_cnt != 0);
    chkw("bundle", obs, m_b);
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins,
                     input logic [31:0] pc, input bit ordy, input bit fl);
    bun_t e;
    bit   er, fi, fo;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    e  = model(ins, pc, 1);
    er = (!m_valid || ordy) && !(div_of(e) && m_cnt != 0);
    #1 chkb("in_ready", in_ready, er);
    @(posedge clk);
    fi = v && er;
    fo = m_valid && ordy;
    if (fl)      m_valid = 0;
    else if (fi) m_valid = 1;
    else if (fo) m_valid = 0;
    if (fi && !fl) m_b = e;
    if (fi && !fl && div_of(e)) m_cnt = 4;
    else if (m_cnt > 0)         m_cnt--;
    #1 check_state();
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40208233;
  localparam logic [31:0] I_DIV  = 32'h0220C2B3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_LW   = 32'h0000A303;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  initial begin
    logic [6:0]  ops [11];
    logic [31:0] ins;
    rtab = '{
      {7'h00, 3'd0, 5'h00}, {7'h20, 3'd0, 5'h10}, {7'h00, 3'd1, 5'h0D},
      {7'h00, 3'd2, 5'h0F}, {7'h00, 3'd3, 5'h11}, {7'h00, 3'd4, 5'h01},
      {7'h00, 3'd5, 5'h12}, {7'h20, 3'd5, 5'h0E}, {7'h00, 3'd6, 5'h03},
      {7'h00, 3'd7, 5'h02}, {7'h01, 3'd0, 5'h04}, {7'h01, 3'd1, 5'h05},
      {7'h01, 3'd2, 5'h07}, {7'h01, 3'd3, 5'h06}, {7'h01, 3'd4, 5'h08},
      {7'h01, 3'd5, 5'h09}, {7'h01, 3'd6, 5'h0A}, {7'h01, 3'd7, 5'h0B}};
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
            7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
    m_valid = 0; m_cnt = 0; m_b = '0;
    in_valid = 0; in_instr = '0; in_pc = '0;
    flush = 0; out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check_state();
    chkb("reset_in_ready", in_ready, 1'b1);
    #3 rst_n = 1'b1;

    cyc(1, I_ADD, 32'h100, 1, 0);
    chkw("add_alu", 68'(alu_op), 68'd0);
    chkw("add_rd", 68'(rd), 68'd3);
    chkb("add_rw", regwrite_enable, 1'b1);

    for (int k = 0; k < 3; k++) cyc(1, I_SUB, 32'h104, 0, 0);
    chkw("hold_pc", 68'(out_pc), 68'h100);
    cyc(1, I_SUB, 32'h104, 1, 0);
    chkw("sub_alu", 68'(alu_op), 68'h10);

    cyc(1, I_DIV, 32'h108, 1, 0);
    cyc(1, I_DIV, 32'h10C, 1, 0);
    cyc(1, I_DIV, 32'h10C, 1, 0);
    chkb("div_gap_busy", div_busy, 1'b1);
    cyc(1, I_MUL, 32'h110, 1, 0);
    chkw("mul_gap_alu", 68'(alu_op), 68'h04);
    cyc(1, I_DIV, 32'h114, 1, 0);
    cyc(1, I_DIV, 32'h114, 1, 0);
    chkw("div2_pc", 68'(out_pc), 68'h114);

    cyc(1, I_LW, 32'h118, 1, 1);
    chkb("flush_valid", out_valid, 1'b0);
    chkb("flush_busy", div_busy, 1'b1);

    cyc(1, I_BAD, 32'h11C, 1, 0);
    chkb("bad_illegal", illegal, 1'b1);
    chkb("bad_rw", regwrite_enable, 1'b0);
    cyc(1, I_MUL, 32'h120, 1, 0);
    chkw("nm_mul", nm_obs, model(I_MUL, 32'h120, 0));
    chkb("nm_mul_illegal", nm_illegal, 1'b1);
    chkb("nm_mul_rw", nm_rw, 1'b0);

    cyc(1, I_DIV, 32'h124, 1, 0);
    in_valid = 1;
    #2 rst_n = 1'b0;
    m_valid = 0; m_cnt = 0; m_b = '0;
    #1 check_state();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(1, I_ADDI, 32'h200, 1, 0);
    chkw("post_rst_rd", 68'(rd), 68'd1);
    chkb("post_rst_m2", mux2_select, 1'b1);

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:25] = 7'h01;
        default: ;
      endcase
      cyc($urandom_range(0, 3) != 0, ins, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
